// File: rtl/code_entry_tx.sv
// code_entry_tx: serial MSB-first nibble entry with hold, timeout and clear handling
module code_entry_tx #(
    parameter int HOLD_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic bit_in,
    input  logic bit_strobe,
    input  logic clear,
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic ready,
    output logic rst_out,
    output logic busy,
    output logic timeout_err,
    output logic overrun
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int GW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, COLLECT, PRESENT, CLEAR} state_t;

    state_t        state, next;
    logic [2:0]    part;
    logic [1:0]    bit_count;
    logic [GW-1:0] gap;
    logic [HW-1:0] hold;
    logic          clr_cnt;
    logic [3:0]    code, code_n;
    logic          ready_n, busy_n, rst_out_n, tmo_n, ovr_n;
    logic          hold_done, tmo, acc;

    assign {A, B, C, D} = code;
    assign hold_done = hold == HW'(HOLD_CYCLES);
    assign tmo = state == COLLECT && !clear && !bit_strobe && gap == GW'(TIMEOUT_CYCLES - 1);
    assign acc = bit_strobe && !clear &&
                 (state == IDLE || state == COLLECT || (state == PRESENT && hold_done));

    // State, datapath counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            part        <= '0;
            bit_count   <= '0;
            gap         <= '0;
            hold        <= '0;
            clr_cnt     <= 1'b0;
            code        <= '0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            rst_out     <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state <= next;
            if (acc) begin
                part      <= state == COLLECT ? {part[1:0], bit_in} : {2'b00, bit_in};
                bit_count <= state == COLLECT ? bit_count + 2'd1 : 2'd1;
            end
            gap         <= (state != COLLECT || acc) ? '0 : gap + 1'b1;
            hold        <= state != PRESENT ? '0 : hold_done ? hold : hold + 1'b1;
            clr_cnt     <= state == CLEAR;
            code        <= code_n;
            ready       <= ready_n;
            busy        <= busy_n;
            rst_out     <= rst_out_n;
            timeout_err <= tmo_n;
            overrun     <= ovr_n;
        end
    end

    // Next-state selection; clear has priority over any strobe
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = clear ? CLEAR : bit_strobe ? COLLECT : IDLE;
            COLLECT: next = clear ? CLEAR : (bit_strobe && bit_count == 2'd3) ? PRESENT : tmo ? IDLE : COLLECT;
            PRESENT: next = clear ? CLEAR : (bit_strobe && hold_done) ? COLLECT : PRESENT;
            default: next = clr_cnt ? IDLE : CLEAR;
        endcase
    end

    // Next values of the registered outputs; partial bits never reach A..D
    always_comb begin
        code_n    = next == PRESENT ? (state == PRESENT ? code : {part, bit_in}) : 4'b0000;
        ready_n   = next == PRESENT;
        busy_n    = next == COLLECT;
        rst_out_n = state == CLEAR;
        tmo_n     = tmo;
        ovr_n     = state == PRESENT && bit_strobe && !clear && !hold_done;
    end
endmodule
